// File: rtl/ring_code_monitor_if.sv
// Code-word link between a ring/Johnson counter (master) and its sequence monitor (slave).
interface ring_code_monitor_if #(
   parameter int unsigned N   = 4,
   parameter int unsigned ECW = 8
);
   localparam int unsigned PW = $clog2(2 * N);

   logic           i_valid;
   logic [N-1:0]   i_code;
   logic [PW-1:0]  o_pos;
   logic           o_pos_valid;
   logic           o_locked;
   logic           o_err_pulse;
   logic [1:0]     o_err_type;
   logic [ECW-1:0] o_err_count;

   modport master (
      output i_valid, i_code,
      input  o_pos, o_pos_valid, o_locked, o_err_pulse, o_err_type, o_err_count
   );

   modport slave (
      input  i_valid, i_code,
      output o_pos, o_pos_valid, o_locked, o_err_pulse, o_err_type, o_err_count
   );
endinterface

// File: rtl/ring_code_monitor.sv
// Receive-side ring/Johnson sequence checker: decodes each valid word, verifies it is the
// successor of the previous one, declares lock after LOCK_CNT good steps, counts errors.
module ring_code_monitor #(
   parameter int unsigned N        = 4,
   parameter int unsigned MODE     = 0,
   parameter int unsigned LOCK_CNT = 3,
   parameter int unsigned ECW      = 8
) (
   input logic               clk,
   input logic               rst,
   ring_code_monitor_if.slave bus
);
   localparam int          S  = (MODE == 0) ? int'(N) : int'(2 * N);
   localparam int unsigned PW = $clog2(2 * N);
   localparam int unsigned CW = $clog2(LOCK_CNT + 1);

   typedef enum logic [1:0] {StHunt, StCheck, StLocked} state_e;

   state_e         r_state;
   logic [N-1:0]   r_prev;
   logic [CW-1:0]  r_match_cnt;
   logic [PW-1:0]  r_pos;
   logic           r_pos_valid;
   logic           r_locked;
   logic           r_err_pulse;
   logic [1:0]     r_err_type;
   logic [ECW-1:0] r_err_count;

   logic           w_legal;
   logic [PW-1:0]  w_pos;
   logic [N-1:0]   w_succ;
   logic           w_match;
   logic [CW-1:0]  w_match_inc;
   logic [ECW-1:0] w_err_inc;

   // Legal code for position k, built straight from the ring/Johnson position formulas.
   function automatic logic [N-1:0] code_at(input int k);
      logic [N:0] t;
      if (MODE == 0) begin
         t = {{N{1'b0}}, 1'b1} << k;
         return t[N-1:0];
      end else if (k <= int'(N)) begin
         t = ({{N{1'b0}}, 1'b1} << k) - 1'b1;
         return t[N-1:0];
      end else begin
         t = ({{N{1'b0}}, 1'b1} << (k - int'(N))) - 1'b1;
         return ~t[N-1:0];
      end
   endfunction

   always_comb begin
      w_legal = 1'b0;
      w_pos   = '0;
      for (int k = 0; k < S; k++) begin
         if (bus.i_code == code_at(k)) begin
            w_legal = 1'b1;
            w_pos   = PW'(k);
         end
      end
   end

   assign w_succ      = (MODE == 0) ? {r_prev[N-2:0], r_prev[N-1]}
                                    : {r_prev[N-2:0], ~r_prev[N-1]};
   assign w_match     = (bus.i_code == w_succ);
   assign w_match_inc = r_match_cnt + 1'b1;
   assign w_err_inc   = (&r_err_count) ? r_err_count : r_err_count + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= StHunt;
         r_prev      <= '0;
         r_match_cnt <= '0;
         r_pos       <= '0;
         r_pos_valid <= 1'b0;
         r_locked    <= 1'b0;
         r_err_pulse <= 1'b0;
         r_err_type  <= 2'd0;
         r_err_count <= '0;
      end else begin
         r_pos_valid <= 1'b0;
         r_err_pulse <= 1'b0;
         r_err_type  <= 2'd0;
         if (bus.i_valid) begin
            if (!w_legal) begin
               // Illegal word: drop back to hunting, keep the last good reference word.
               r_err_pulse <= 1'b1;
               r_err_type  <= 2'd1;
               r_err_count <= w_err_inc;
               r_locked    <= 1'b0;
               r_match_cnt <= '0;
               r_state     <= StHunt;
            end else begin
               r_pos_valid <= 1'b1;
               r_pos       <= w_pos;
               r_prev      <= bus.i_code;
               unique case (r_state)
                  StHunt: begin
                     r_match_cnt <= '0;
                     r_state     <= StCheck;
                  end
                  StCheck: begin
                     if (w_match) begin
                        r_match_cnt <= w_match_inc;
                        if (w_match_inc == CW'(LOCK_CNT)) begin
                           r_state  <= StLocked;
                           r_locked <= 1'b1;
                        end
                     end else begin
                        r_err_pulse <= 1'b1;
                        r_err_type  <= 2'd2;
                        r_err_count <= w_err_inc;
                        r_match_cnt <= '0;
                     end
                  end
                  StLocked: begin
                     if (!w_match) begin
                        r_err_pulse <= 1'b1;
                        r_err_type  <= 2'd2;
                        r_err_count <= w_err_inc;
                        r_match_cnt <= '0;
                        r_locked    <= 1'b0;
                        r_state     <= StCheck;
                     end
                  end
                  default: r_state <= StHunt;
               endcase
            end
         end
      end
   end

   assign bus.o_pos       = r_pos;
   assign bus.o_pos_valid = r_pos_valid;
   assign bus.o_locked    = r_locked;
   assign bus.o_err_pulse = r_err_pulse;
   assign bus.o_err_type  = r_err_type;
   assign bus.o_err_count = r_err_count;
endmodule

// File: tb/tb_ring_code_monitor.sv
// Bench for ring_code_monitor: ring (ECW=8), Johnson (ECW=8) and ring (ECW=2) instances
// checked against a position-arithmetic reference model.
module tb_ring_code_monitor;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   ring_code_monitor_if #(.N(4), .ECW(8)) if_r ();
   ring_code_monitor_if #(.N(4), .ECW(8)) if_j ();
   ring_code_monitor_if #(.N(4), .ECW(2)) if_s ();

   ring_code_monitor #(.N(4), .MODE(0), .LOCK_CNT(3), .ECW(8)) dut_r (
      .clk(clk), .rst(rst), .bus(if_r.slave));
   ring_code_monitor #(.N(4), .MODE(1), .LOCK_CNT(3), .ECW(8)) dut_j (
      .clk(clk), .rst(rst), .bus(if_j.slave));
   ring_code_monitor #(.N(4), .MODE(0), .LOCK_CNT(3), .ECW(2)) dut_s (
      .clk(clk), .rst(rst), .bus(if_s.slave));

   // Reference model state, one slot per instance: 0 ring, 1 Johnson, 2 ring with ECW=2.
   int ch_mode [3] = '{0, 1, 0};
   int ch_max  [3] = '{255, 255, 3};
   int m_hunt [3];
   int m_prev [3];
   int m_run  [3];
   int m_lock [3];
   int m_err  [3];
   int m_pos  [3];
   int m_pv   [3];
   int m_ep   [3];
   int m_et   [3];

   function automatic int n_states(input int mode);
      return (mode == 0) ? 4 : 8;
   endfunction

   function automatic logic [3:0] code_of(input int mode, input int k);
      int v;
      if (mode == 0) v = 1 << k;
      else if (k <= 4) v = (1 << k) - 1;
      else v = (~((1 << (k - 4)) - 1)) & 15;
      return v[3:0];
   endfunction

   function automatic int lookup(input int mode, input logic [3:0] c);
      for (int k = 0; k < n_states(mode); k++)
         if (code_of(mode, k) == c) return k;
      return -1;
   endfunction

   task automatic model_reset();
      for (int ch = 0; ch < 3; ch++) begin
         m_hunt[ch] = 1; m_prev[ch] = 0; m_run[ch] = 0; m_lock[ch] = 0; m_err[ch] = 0;
         m_pos[ch] = 0;  m_pv[ch] = 0;   m_ep[ch] = 0;  m_et[ch] = 0;
      end
   endtask

   task automatic model_step(input int ch, input logic v, input logic [3:0] c);
      int p;
      m_pv[ch] = 0; m_ep[ch] = 0; m_et[ch] = 0;
      if (!v) return;
      p = lookup(ch_mode[ch], c);
      if (p < 0) begin
         m_ep[ch] = 1; m_et[ch] = 1; m_lock[ch] = 0; m_hunt[ch] = 1; m_run[ch] = 0;
      end else begin
         m_pv[ch] = 1; m_pos[ch] = p;
         if (m_hunt[ch] != 0) begin
            m_hunt[ch] = 0; m_run[ch] = 0;
         end else if (p == (m_prev[ch] + 1) % n_states(ch_mode[ch])) begin
            m_run[ch]++;
            if (m_run[ch] >= 3) m_lock[ch] = 1;
         end else begin
            m_ep[ch] = 1; m_et[ch] = 2; m_run[ch] = 0; m_lock[ch] = 0;
         end
         m_prev[ch] = p;
      end
      if (m_ep[ch] != 0 && m_err[ch] < ch_max[ch]) m_err[ch]++;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_ch(input int ch, input string nm, input int pos, input int pv,
                           input int lk, input int ep, input int et, input int ec);
      chk({nm, ".pos_valid"}, pv, m_pv[ch]);
      chk({nm, ".pos_out"}, pos, m_pos[ch]);
      chk({nm, ".locked"}, lk, m_lock[ch]);
      chk({nm, ".err_pulse"}, ep, m_ep[ch]);
      chk({nm, ".err_type"}, et, m_et[ch]);
      chk({nm, ".err_count"}, ec, m_err[ch]);
   endtask

   task automatic check_all();
      check_ch(0, "ring", int'(if_r.o_pos), int'(if_r.o_pos_valid), int'(if_r.o_locked),
               int'(if_r.o_err_pulse), int'(if_r.o_err_type), int'(if_r.o_err_count));
      check_ch(1, "john", int'(if_j.o_pos), int'(if_j.o_pos_valid), int'(if_j.o_locked),
               int'(if_j.o_err_pulse), int'(if_j.o_err_type), int'(if_j.o_err_count));
      check_ch(2, "sat", int'(if_s.o_pos), int'(if_s.o_pos_valid), int'(if_s.o_locked),
               int'(if_s.o_err_pulse), int'(if_s.o_err_type), int'(if_s.o_err_count));
   endtask

   // Ring word goes to both ring instances, Johnson word to the Johnson instance.
   task automatic step(input logic v0, input logic [3:0] c0, input logic v1,
                       input logic [3:0] c1);
      if_r.i_valid = v0; if_r.i_code = c0;
      if_s.i_valid = v0; if_s.i_code = c0;
      if_j.i_valid = v1; if_j.i_code = c1;
      @(posedge clk);
      model_step(0, v0, c0);
      model_step(2, v0, c0);
      model_step(1, v1, c1);
      #1;
      check_all();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      if_r.i_valid = 1'b0; if_s.i_valid = 1'b0; if_j.i_valid = 1'b0;
      @(posedge clk);
      model_reset();
      #1;
      check_all();
      rst = 1'b0;
   endtask

   initial begin
      int rp, jp;
      logic       rv, jv;
      logic [3:0] rc, jc;
      if_r.i_code = '0; if_s.i_code = '0; if_j.i_code = '0;
      model_reset();
      do_reset();

      // Ring lock-in alongside Johnson 0000..0111.
      step(1'b1, 4'b0001, 1'b1, 4'b0000);
      step(1'b1, 4'b0010, 1'b1, 4'b0001);
      step(1'b1, 4'b0100, 1'b1, 4'b0011);
      step(1'b1, 4'b1000, 1'b1, 4'b0111);
      // Ring wrap then sequence error; Johnson keeps walking.
      step(1'b1, 4'b0001, 1'b1, 4'b1111);
      step(1'b1, 4'b0100, 1'b1, 4'b1110);
      // Ring illegal words, then recovery.
      step(1'b1, 4'b0011, 1'b1, 4'b1100);
      step(1'b1, 4'b0000, 1'b1, 4'b1000);
      step(1'b1, 4'b0010, 1'b1, 4'b0000);
      // Ring relocks; Johnson gets an illegal word then hunts again.
      step(1'b1, 4'b0100, 1'b1, 4'b1010);
      step(1'b1, 4'b1000, 1'b1, 4'b0000);
      step(1'b1, 4'b0001, 1'b1, 4'b0001);
      step(1'b1, 4'b0010, 1'b1, 4'b0011);
      // Stall does not advance the expected word.
      for (int i = 0; i < 5; i++) step(1'b0, 4'b1111, 1'b0, 4'b1111);
      step(1'b1, 4'b0100, 1'b1, 4'b0111);
      step(1'b1, 4'b0100, 1'b1, 4'b0111);

      // Mostly-successor random traffic with stalls, jumps and junk words.
      rp = 2; jp = 3;
      for (int i = 0; i < 300; i++) begin
         rv = ($urandom_range(0, 99) >= 10);
         jv = ($urandom_range(0, 99) >= 10);
         if (rv) begin
            int r = $urandom_range(0, 99);
            if (r < 75) rp = (rp + 1) % 4;
            else if (r < 88) rp = $urandom_range(0, 3);
            rc = (r < 88) ? code_of(0, rp) : 4'($urandom_range(0, 15));
         end else rc = 4'($urandom_range(0, 15));
         if (jv) begin
            int r = $urandom_range(0, 99);
            if (r < 75) jp = (jp + 1) % 8;
            else if (r < 88) jp = $urandom_range(0, 7);
            jc = (r < 88) ? code_of(1, jp) : 4'($urandom_range(0, 15));
         end else jc = 4'($urandom_range(0, 15));
         step(rv, rc, jv, jc);
      end

      // Reset in the middle of a locked run clears everything.
      do_reset();
      step(1'b1, 4'b0001, 1'b1, 4'b0000);
      step(1'b1, 4'b0010, 1'b1, 4'b0001);
      step(1'b1, 4'b0100, 1'b1, 4'b0011);
      step(1'b1, 4'b1000, 1'b1, 4'b0111);
      do_reset();
      // Five errors against a 2-bit counter.
      for (int i = 0; i < 5; i++) step(1'b1, 4'b0000, 1'b1, 4'b0101);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
